hazard_ctrl: RTL

// - Pipeline hazard unit: drives the stall/flush inputs of IF/ID, ID/EX (flushE, stallE) and EX/MEM,

---
 rtl/hazard_ctrl_pkg.sv | 28 ++
 rtl/md_stall_fsm.sv | 92 +++++++++
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types, constants and helpers for the pipeline hazard unit.
package hazard_ctrl_pkg;

   // Register specifier width
   localparam int REG_SIZE = 5;

   // EX operand forwarding selects
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Multi-cycle (MULT/DIV) hold FSM states
   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   // A source register depends on a later stage's result only when that stage
   // really writes the register file and the destination is not the zero register.
   function automatic logic reg_match(
      input logic                we,
      input logic [REG_SIZE-1:0] wr,
      input logic [REG_SIZE-1:0] src
   );
      return we && (wr != 5'd0) && (wr == src);
   endfunction

endpackage

// File: rtl/md_stall_fsm.sv
// Hold FSM for multi-cycle MULT/DIV ops: keeps EX stationary for exactly
// N cycles (N = DIV_CYCLES or MULT_CYCLES) and pulses mdDone on the final one.
module md_stall_fsm
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic mdStartE,
   input  logic mdDivE,
   output logic mdStall,
   output logic mdBusy,
   output logic mdDone
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   // The IDLE cycle that accepts the op is already a stall cycle, so the
   // counter loads N-1 and the op leaves EX on the cycle it reaches zero.
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   md_state_e        r_state;
   md_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_stall;
   logic             w_done;

   // State and countdown registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= MD_IDLE;
         r_cnt   <= CNT_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state, countdown and raw stall/done decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stall     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         MD_IDLE: begin
            if (mdStartE) begin
               w_state_nxt = MD_BUSY;
               w_cnt_nxt   = mdDivE ? DIV_LOAD : MULT_LOAD;
               w_stall     = 1'b1;
            end else begin
               w_state_nxt = MD_IDLE;
            end
         end
         MD_BUSY: begin
            // mdStartE here belongs to the op being held, so it never restarts the count
            if (r_cnt != CNT_ZERO) begin
               w_cnt_nxt = r_cnt - CNT_ONE;
               w_stall   = 1'b1;
            end else begin
               w_state_nxt = MD_IDLE;
               w_done      = 1'b1;
            end
         end
         default: begin
            w_state_nxt = MD_IDLE;
            w_cnt_nxt   = CNT_ZERO;
         end
      endcase
   end

   // Outputs forced low while reset is held so stalls drop the same instant
   always_comb begin
      if (!rst) begin
         mdStall = 1'b0;
         mdBusy  = 1'b0;
         mdDone  = 1'b0;
      end else begin
         mdStall = w_stall;
         mdBusy  = (r_state == MD_BUSY);
         mdDone  = w_done;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects for EX and the ID branch compare,
// load-use / branch stalls, taken-branch flush, and multi-cycle op holds.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_SIZE-1:0] rsD,
   input  logic [REG_SIZE-1:0] rtD,
   input  logic [REG_SIZE-1:0] rsE,
   input  logic [REG_SIZE-1:0] rtE,
   input  logic [REG_SIZE-1:0] writeRegE,
   input  logic [REG_SIZE-1:0] writeRegM,
   input  logic [REG_SIZE-1:0] writeRegW,
   input  logic                Regfile_weE,
   input  logic                Regfile_weM,
   input  logic                Regfile_weW,
   input  logic                memToRegE,
   input  logic                memToRegM,
   input  logic                branchD,
   input  logic                pcSrcD,
   input  logic                mdStartE,
   input  logic                mdDivE,
   output logic                stallF,
   output logic                stallD,
   output logic                stallE,
   output logic                flushD,
   output logic                flushE,
   output logic                flushM,
   output logic [1:0]          forwardAE,
   output logic [1:0]          forwardBE,
   output logic                forwardAD,
   output logic                forwardBD,
   output logic                mdBusy,
   output logic                mdDone
);

   logic w_md_stall;
   logic w_md_busy;
   logic w_md_done;

   logic w_rs_e_m;
   logic w_rs_e_w;
   logic w_rt_e_m;
   logic w_rt_e_w;
   logic w_rs_d_e;
   logic w_rt_d_e;
   logic w_rs_d_m;
   logic w_rt_d_m;
   logic w_lw_stall;
   logic w_br_stall;

   md_stall_fsm #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_fsm (
      .clk      (clk),
      .rst      (rst),
      .mdStartE (mdStartE),
      .mdDivE   (mdDivE),
      .mdStall  (w_md_stall),
      .mdBusy   (w_md_busy),
      .mdDone   (w_md_done)
   );

   assign w_rs_e_m = reg_match(Regfile_weM, writeRegM, rsE);
   assign w_rs_e_w = reg_match(Regfile_weW, writeRegW, rsE);
   assign w_rt_e_m = reg_match(Regfile_weM, writeRegM, rtE);
   assign w_rt_e_w = reg_match(Regfile_weW, writeRegW, rtE);
   assign w_rs_d_e = reg_match(Regfile_weE, writeRegE, rsD);
   assign w_rt_d_e = reg_match(Regfile_weE, writeRegE, rtD);
   assign w_rs_d_m = reg_match(Regfile_weM, writeRegM, rsD);
   assign w_rt_d_m = reg_match(Regfile_weM, writeRegM, rtD);

   // A load in EX cannot forward in time for an ID consumer
   assign w_lw_stall = memToRegE && (w_rs_d_e || w_rt_d_e);

   // The ID branch compare needs its operands now: anything still in EX,
   // or a load still in MEM, forces a wait
   assign w_br_stall = branchD &&
                       ((w_rs_d_e || w_rt_d_e) ||
                        (memToRegM && (w_rs_d_m || w_rt_d_m)));

   // Forwarding selects, stall/flush priority, all gated low during reset
   always_comb begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushM    = 1'b0;
      forwardAE = FWD_REG;
      forwardBE = FWD_REG;
      forwardAD = 1'b0;
      forwardBD = 1'b0;
      mdBusy    = 1'b0;
      mdDone    = 1'b0;
      if (!rst) begin
         stallF = 1'b0;
      end else begin
         // MEM is the newer result, so it wins over WB
         if (w_rs_e_m) begin
            forwardAE = FWD_MEM;
         end else if (w_rs_e_w) begin
            forwardAE = FWD_WB;
         end else begin
            forwardAE = FWD_REG;
         end
         if (w_rt_e_m) begin
            forwardBE = FWD_MEM;
         end else if (w_rt_e_w) begin
            forwardBE = FWD_WB;
         end else begin
            forwardBE = FWD_REG;
         end
         forwardAD = w_rs_d_m && !memToRegM;
         forwardBD = w_rt_d_m && !memToRegM;
         mdBusy    = w_md_busy;
         mdDone    = w_md_done;

         if (w_md_stall) begin
            // Hold the op in EX; bubble MEM instead, never kill EX or flush ID
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
         end else if (w_lw_stall || w_br_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end else if (pcSrcD) begin
            flushD = 1'b1;
         end else begin
            flushD = 1'b0;
         end
      end
   end

endmodule
